lcd_sequencer: RTL

Sequences the HD44780-style character LCD: runs the power-on initialisation, then accepts byte writes from a host and drives the LCD bus pins. Every wait is timed by the companion flag timer (flag_controller, 50 MHz), which it restarts through `flag_rst` and polls through the flag inputs. It sits between the host logic and the LCD pads.

---
 rtl/lcd_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_sequencer.sv
// lcd_sequencer
//   Drives an HD44780-style character LCD over its 8-bit parallel bus.
//   After reset it runs the power-on initialisation (eight command bytes,
//   each followed by its own settling wait). It then accepts single byte
//   writes from the host. All waits are timed by an external flag timer:
//   this block restarts the timer with flag_rst and polls its sticky flags.
//
// Configuration macro:
//   LCD_BOOT_HOLD_EN - when defined, a BOOT_HOLD state follows the init
//                      sequence and waits for flag_2s before ready rises.
//                      When undefined, flag_2s is unused and init_done and
//                      ready rise together.
//
// Ports:
//   clk            in   system clock (50 MHz)
//   rst            in   synchronous, active-high reset
//   flag_*         in   sticky timer flags (250ns .. 2s)
//   flag_rst       out  timer restart, one cycle at the start of each wait
//   wr_valid       in   host write request
//   wr_rs          in   0 = command, 1 = data
//   wr_data[7:0]   in   byte to write
//   ready          out  idle and able to accept a host write
//   init_done      out  initialisation finished (sticky until reset)
//   lcd_rs         out  LCD register select
//   lcd_rw         out  LCD read/write (always write)
//   lcd_en         out  LCD enable strobe
//   lcd_data[7:0]  out  LCD data bus
//   fsm_state[2:0] out  current FSM state, for observation only
//
// Host handshake: a write is taken in any cycle where wr_valid and ready
// are both 1; wr_rs and wr_data are captured in that cycle and ready is 0
// from the next cycle until the write's settling wait has elapsed. A
// wr_valid seen while ready is 0 is simply ignored (nothing is queued).

module lcd_sequencer #(
    parameter logic [7:0] INIT_FUNC  = 8'h38,
    parameter logic [7:0] INIT_DISP  = 8'h0C,
    parameter logic [7:0] INIT_ENTRY = 8'h06
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_250ns,
    input  logic       flag_42us,
    input  logic       flag_100us,
    input  logic       flag_1640us,
    input  logic       flag_4100us,
    input  logic       flag_15000us,
    input  logic       flag_2s,
    output logic       flag_rst,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        ST_PWR_WAIT  = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_EXEC      = 3'd3,
        ST_IDLE      = 3'd4
`ifdef LCD_BOOT_HOLD_EN
        ,
        ST_BOOT_HOLD = 3'd5
`endif
    } state_t;

    // Which timer flag ends the EXEC state of the byte in flight.
    typedef enum logic [1:0] {
        WAIT_42   = 2'd0,
        WAIT_100  = 2'd1,
        WAIT_1640 = 2'd2,
        WAIT_4100 = 2'd3
    } wait_t;

    state_t     state;
    logic [2:0] idx;
    wait_t      wait_sel;
    logic       wait_hit;

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0, 3'd1, 3'd2: b = 8'h30;
            3'd3:             b = INIT_FUNC;
            3'd4:             b = 8'h08;
            3'd5:             b = 8'h01;
            3'd6:             b = INIT_ENTRY;
            default:          b = INIT_DISP;
        endcase
        return b;
    endfunction

    function automatic wait_t init_wait(input logic [2:0] i);
        wait_t w;
        case (i)
            3'd0:       w = WAIT_4100;
            3'd1, 3'd2: w = WAIT_100;
            3'd5:       w = WAIT_1640;
            default:    w = WAIT_42;
        endcase
        return w;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic wait_t host_wait(input logic rs, input logic [7:0] d);
        return (!rs && d[7:2] == 6'd0 && d != 8'd0) ? WAIT_1640 : WAIT_42;
    endfunction

    always_comb begin
        wait_hit = 1'b0;
        case (wait_sel)
            WAIT_42:   wait_hit = flag_42us;
            WAIT_100:  wait_hit = flag_100us;
            WAIT_1640: wait_hit = flag_1640us;
            WAIT_4100: wait_hit = flag_4100us;
            default:   wait_hit = 1'b0;
        endcase
    end

    assign lcd_rw    = 1'b0;
    assign fsm_state = state;

`ifndef LCD_BOOT_HOLD_EN
    logic unused_flag_2s;
    assign unused_flag_2s = flag_2s;
`endif

    // flag_rst doubles as the "first cycle of a timed state" marker: it is
    // set on entry to every timed state, and while it is high the (possibly
    // stale) timer flags are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_PWR_WAIT;
            idx       <= 3'd0;
            wait_sel  <= WAIT_42;
            flag_rst  <= 1'b1;
            ready     <= 1'b0;
            init_done <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            flag_rst <= 1'b0;
            case (state)
                ST_PWR_WAIT: begin
                    if (!flag_rst && flag_15000us) begin
                        state    <= ST_SETUP;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_byte(idx);
                        wait_sel <= init_wait(idx);
                    end
                end
                ST_SETUP: begin
                    state    <= ST_PULSE;
                    lcd_en   <= 1'b1;
                    flag_rst <= 1'b1;
                end
                ST_PULSE: begin
                    if (!flag_rst && flag_250ns) begin
                        state    <= ST_EXEC;
                        lcd_en   <= 1'b0;
                        flag_rst <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!flag_rst && wait_hit) begin
                        if (init_done) begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                        end else if (idx == 3'd7) begin
                            init_done <= 1'b1;
`ifdef LCD_BOOT_HOLD_EN
                            state    <= ST_BOOT_HOLD;
                            flag_rst <= 1'b1;
`else
                            state <= ST_IDLE;
                            ready <= 1'b1;
`endif
                        end else begin
                            idx      <= idx + 3'd1;
                            state    <= ST_SETUP;
                            lcd_rs   <= 1'b0;
                            lcd_data <= init_byte(idx + 3'd1);
                            wait_sel <= init_wait(idx + 3'd1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (wr_valid && ready) begin
                        state    <= ST_SETUP;
                        ready    <= 1'b0;
                        lcd_rs   <= wr_rs;
                        lcd_data <= wr_data;
                        wait_sel <= host_wait(wr_rs, wr_data);
                    end
                end
`ifdef LCD_BOOT_HOLD_EN
                ST_BOOT_HOLD: begin
                    if (!flag_rst && flag_2s) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= ST_PWR_WAIT;
                    flag_rst <= 1'b1;
                    lcd_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule
